// File: rtl/flash_frame_sequencer.sv
// flash_frame_sequencer: steps a flash word address through an animation strip with dwell, loop/ping-pong/one-shot playback
//   clk, rst          clock, synchronous active-high reset
//   start             pulse: (re)start playback at frame 0, pixel 0, latching mode
//   en                run enable, low freezes everything and masks addr_valid
//   mode              0 loop, 1 ping-pong, 2 one-shot, 3 loop
//   dwell             each address is held at least dwell+1 cycles
//   addr_ready        flash read path accepts flash_address
//   flash_address     BASE_ADDR + frame_idx*FRAME_W*FRAME_H + pix
//   addr_valid        flash_address is due for issue
//   frame_idx         current frame
//   frame_done        pulse the cycle after a frame's last pixel is accepted
//   busy              playback running
//   pix_x, pix_y, line_done   only with FLASH_SEQ_XY_EN defined: pixel coordinates and end-of-line pulse
module flash_frame_sequencer #(
    parameter int ADDR_W = 32,
    parameter int FRAME_W = 125,
    parameter int FRAME_H = 250,
    parameter int NUM_FRAMES = 4,
    parameter int unsigned BASE_ADDR = 0,
    parameter int DWELL_W = 11,
    localparam int FRAME_SIZE = FRAME_W * FRAME_H,
    localparam int PIX_W = FRAME_SIZE > 1 ? $clog2(FRAME_SIZE) : 1,
    localparam int FI_W = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1,
    localparam int XW = FRAME_W > 1 ? $clog2(FRAME_W) : 1,
    localparam int YW = FRAME_H > 1 ? $clog2(FRAME_H) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               addr_ready,
    output logic [ADDR_W-1:0]  flash_address,
    output logic               addr_valid,
    output logic [FI_W-1:0]    frame_idx,
    output logic               frame_done,
`ifdef FLASH_SEQ_XY_EN
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic               line_done,
`endif
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [PIX_W-1:0] pix;
    logic [DWELL_W-1:0] cnt;
    logic [1:0] mode_q;
    logic dir_back, acc, last_pix, last_frame, first_frame, finish, pp, going_fwd;
    logic [FI_W-1:0] frame_nxt;
    logic dir_nxt;

    assign acc = addr_valid && addr_ready;
    assign last_pix = pix == PIX_W'(FRAME_SIZE - 1);
    assign last_frame = frame_idx == FI_W'(NUM_FRAMES - 1);
    assign first_frame = frame_idx == '0;
    assign finish = mode_q == 2'd2 && last_frame;
    assign pp = mode_q == 2'd1 && NUM_FRAMES > 1;
    // ping-pong bounces off either end of the strip
    assign going_fwd = dir_back ? first_frame : !last_frame;
    assign frame_nxt = pp ? (going_fwd ? frame_idx + FI_W'(1) : frame_idx - FI_W'(1))
                          : (last_frame ? '0 : frame_idx + FI_W'(1));
    assign dir_nxt = pp ? !going_fwd : dir_back;
    assign flash_address = ADDR_W'(BASE_ADDR) + ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE) + ADDR_W'(pix);

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb
        state_nxt = start ? RUN : (state == RUN && acc && last_pix && finish) ? DONE : state;

    always_comb begin
        busy = state == RUN;
        addr_valid = busy && en && cnt >= dwell;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            pix <= '0;
            frame_idx <= '0;
            cnt <= '0;
            dir_back <= 1'b0;
            frame_done <= 1'b0;
            mode_q <= rst ? 2'd0 : mode;
        end else begin
            frame_done <= acc && last_pix;
            if (acc) begin
                cnt <= '0;
                if (!last_pix)
                    pix <= pix + PIX_W'(1);
                else if (!finish) begin
                    pix <= '0;
                    frame_idx <= frame_nxt;
                    dir_back <= dir_nxt;
                end
                if (last_pix)
                    mode_q <= mode;
            end else if (busy && en && !addr_valid)
                cnt <= cnt + DWELL_W'(1);
        end
    end

`ifdef FLASH_SEQ_XY_EN
    logic last_x;
    assign last_x = pix_x == XW'(FRAME_W - 1);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            pix_x <= '0;
            pix_y <= '0;
            line_done <= 1'b0;
        end else begin
            line_done <= acc && last_x;
            // one-shot completion leaves the coordinates on the final pixel
            if (acc && !(last_pix && finish)) begin
                pix_x <= last_x ? '0 : pix_x + XW'(1);
                pix_y <= last_pix ? '0 : last_x ? pix_y + YW'(1) : pix_y;
            end
        end
    end
`endif
endmodule

// File: tb/tb_flash_frame_sequencer.sv
// tb_flash_frame_sequencer: self-checking bench for flash_frame_sequencer on a 4x2 pixel, 3-frame strip
module tb_flash_frame_sequencer;
    localparam int FW = 4, FH = 2, NF = 3, FS = FW * FH;

    logic clk = 1'b0, rst, start, en, addr_ready, addr_valid, frame_done, busy;
    logic [1:0] mode, frame_idx;
    logic [10:0] dwell;
    logic [31:0] flash_address;

    always #5 clk = ~clk;

    flash_frame_sequencer #(
        .ADDR_W(32), .FRAME_W(FW), .FRAME_H(FH), .NUM_FRAMES(NF), .BASE_ADDR(0), .DWELL_W(11)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .mode(mode), .dwell(dwell),
        .addr_ready(addr_ready), .flash_address(flash_address), .addr_valid(addr_valid),
        .frame_idx(frame_idx), .frame_done(frame_done), .busy(busy)
    );

    typedef struct {
        logic [1:0] m;
        int d;
        int n;
        logic busy_end;
    } vec_t;

    int total = 0, bad = 0;
    logic [31:0] q[$];
    bit mon_on = 1'b0, fd_prev = 1'b0;
    int exp_gap = 0, since = 0;
    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [1:0] m, input int k);
        int f, fr;
        f = k / FS;
        fr = (m == 2'd1) ? ((f % 4 == 3) ? 1 : f % 4) : f % NF;
        return 32'(fr * FS + k % FS);
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        if (!mon_on)
            fd_prev = 1'b0;
        else if (start) begin
            since = 0;
            fd_prev = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(fd_prev));
            fd_prev = 1'b0;
            if (addr_valid && addr_ready) begin
                if (q.size() == 0)
                    chk("extra_accept", flash_address, 32'hFFFF_FFFF);
                else begin
                    e = q.pop_front();
                    chk("addr", flash_address, e);
                    chk("frame_idx", 32'(frame_idx), e / FS);
                    if (exp_gap != 0)
                        chk("gap", 32'(since + 1), 32'(exp_gap));
                end
                fd_prev = (flash_address % FS) == FS - 1;
                since = 0;
            end else
                since++;
        end
    end

    task automatic pulse_start(input bit mon);
        @(posedge clk);
        #1 start = 1'b1;
        mon_on = mon;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input vec_t v);
        int n;
        mode = v.m;
        dwell = 11'(v.d);
        addr_ready = 1'b1;
        en = 1'b1;
        exp_gap = v.d + 1;
        for (int k = 0; k < v.n; k++)
            q.push_back(exp_addr(v.m, k));
        pulse_start(1'b1);
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1 n++;
        end
        if (q.size() != 0) begin
            chk("drain", 32'(q.size()), 0);
            q.delete();
        end
        if (v.busy_end)
            mon_on = 1'b0;
        else begin
            repeat (6) @(posedge clk);
            #1;
        end
        chk("busy_end", 32'(busy), 32'(v.busy_end));
        if (!v.busy_end) begin
            chk("done_valid", 32'(addr_valid), 0);
            chk("done_addr", flash_address, exp_addr(v.m, v.n - 1));
            mon_on = 1'b0;
        end
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        while (flash_address !== a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (flash_address !== a)
            chk("wait_addr", flash_address, a);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{m: 2'd0, d: 3, n: 26, busy_end: 1'b1};
        vt[1] = '{m: 2'd1, d: 3, n: 48, busy_end: 1'b1};
        vt[2] = '{m: 2'd3, d: 0, n: 26, busy_end: 1'b1};
        vt[3] = '{m: 2'd2, d: 0, n: 24, busy_end: 1'b0};
        vt[4] = '{m: 2'd1, d: 1, n: 20, busy_end: 1'b1};
        vt[5] = '{m: 2'd2, d: 3, n: 24, busy_end: 1'b0};
        rst = 1'b1;
        start = 1'b0;
        en = 1'b1;
        addr_ready = 1'b0;
        mode = 2'd0;
        dwell = 11'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(addr_valid), 0);
        chk("rst_addr", flash_address, 0);
        chk("rst_frame", 32'(frame_idx), 0);
        chk("rst_fd", 32'(frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
        end

        foreach (vt[i])
            run(vt[i]);

        // restart from DONE
        pulse_start(1'b0);
        @(negedge clk);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_addr", flash_address, 0);
        chk("restart_valid", 32'(addr_valid), 0);

        // back-pressure on the last pixel of frame 0
        mode = 2'd0;
        dwell = 11'd0;
        addr_ready = 1'b1;
        pulse_start(1'b0);
        wait_addr(7);
        addr_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_addr", flash_address, 7);
            chk("stall_valid", 32'(addr_valid), 1);
            chk("stall_fd", 32'(frame_done), 0);
        end
        addr_ready = 1'b1;
        @(negedge clk);
        addr_ready = 1'b0;
        chk("step_addr", flash_address, 8);
        chk("step_frame", 32'(frame_idx), 1);
        chk("step_fd", 32'(frame_done), 1);
        @(negedge clk);
        chk("step_hold", flash_address, 8);
        chk("step_fd_end", 32'(frame_done), 0);

        // pause mid-dwell
        dwell = 11'd7;
        addr_ready = 1'b1;
        en = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pre_pause_valid", 32'(addr_valid), 0);
        end
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("pause_valid", 32'(addr_valid), 0);
            chk("pause_addr", flash_address, 0);
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("resume_valid", 32'(addr_valid), 32'(i == 5));
        end

        // reset beats start mid-frame
        dwell = 11'd0;
        pulse_start(1'b0);
        wait_addr(10);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_valid", 32'(addr_valid), 0);
        chk("mrst_addr", flash_address, 0);
        chk("mrst_frame", 32'(frame_idx), 0);
        chk("mrst_fd", 32'(frame_done), 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_addr", flash_address, 0);
            chk("post_rst_valid", 32'(addr_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flash_frame_sequencer.md
Name: flash_frame_sequencer

Overview:
Parametrised flash address generator for sprite/animation playback. Steps a flash address through NUM_FRAMES consecutive image frames of FRAME_W*FRAME_H words each, holding each address for a programmable dwell period. Supports loop, ping-pong and one-shot playback, pause and start/stop control. Presents addresses to the flash read path over a valid/ready handshake.

Parameters:
ADDR_W, 32, width of flash_address
FRAME_W, 125, pixels per line
FRAME_H, 250, lines per frame
NUM_FRAMES, 4, frames in the animation strip (>=1)
BASE_ADDR, 0, flash address of pixel 0 of frame 0
DWELL_W, 11, width of the dwell input and dwell counter

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; begins playback from frame 0, pixel 0
en  in  1  run enable; low = pause (all state frozen)
mode  in  2  0=loop, 1=ping-pong, 2=one-shot, 3=reserved (treated as loop)
dwell  in  DWELL_W  hold count; each address is held dwell+1 cycles minimum
addr_ready  in  1  flash read path accepts current address
flash_address  out  ADDR_W  current flash word address
addr_valid  out  1  flash_address is due for issue
frame_idx  out  clog2(NUM_FRAMES) max 1  current frame number
frame_done  out  1  one-cycle pulse when a frame's last pixel is accepted
busy  out  1  high while in RUN

Behaviour:
- FRAME_SIZE = FRAME_W*FRAME_H. flash_address = BASE_ADDR + frame_idx*FRAME_SIZE + pix; sum truncated to ADDR_W. pix counts 0..FRAME_SIZE-1.
- Reset: state IDLE, flash_address=BASE_ADDR, pix=0, frame_idx=0, dwell counter cnt=0, direction=forward, addr_valid=0, frame_done=0, busy=0. rst has priority over start and all other inputs.
- States: IDLE, RUN, DONE. IDLE/DONE --start--> RUN, with pix=0, frame_idx=0, cnt=0, direction=forward, mode latched. start while in RUN restarts the same way.
- busy=1 exactly when state==RUN.
- addr_valid = RUN && cnt>=dwell, from registered state. Comparison is >=, so lowering dwell mid-hold takes effect immediately.
- In RUN with en=1: if !addr_valid, cnt increments. If addr_valid && addr_ready, the address advances and cnt clears to 0. If addr_valid && !addr_ready, cnt and address hold.
- en=0: cnt, pix, frame, state frozen; addr_valid forced low.
- Latency: with dwell=D and ready tied high, each address is held D+1 cycles, the last address of the strip included. D=2047 steps every 2048 cycles.
- Address advance: pix+1. At pix==FRAME_SIZE-1: pix wraps to 0, frame_done pulses in the following cycle, the next frame is chosen by the latched mode, then mode is re-latched.
  - loop: frame+1, wrapping NUM_FRAMES-1 -> 0.
  - ping-pong: step in the current direction; reverse at frame 0 and NUM_FRAMES-1 (sequence 0,1,..,N-1,N-2,..,0,1..). NUM_FRAMES=1 stays on 0.
  - one-shot: after the last frame completes, go to DONE. pix and frame hold at their final values, so flash_address holds the last address. addr_valid=0.
- mode changes mid-frame take effect only at the next frame boundary.
- start and a handshake in the same cycle: start wins.

Optional Feature:
FLASH_SEQ_XY_EN
- Defined: adds outputs pix_x (clog2(FRAME_W)) and pix_y (clog2(FRAME_H)), tracked incrementally with no divider. x advances with pix; on x==FRAME_W-1, x wraps to 0 and y increments; both clear at frame wrap, start and rst.
- Also adds line_done, a one-cycle pulse when the last pixel of a line is accepted.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. FRAME_W=4, FRAME_H=2, NUM_FRAMES=3, mode=0, dwell=3, ready=1, start -> addresses 0..23, each held 4 cycles, then wraps to 0. frame_done pulses after accepts of 7, 15 and 23.
2. Same config, mode=1 -> frame_idx sequence 0,1,2,1,0,1. After address 23 comes 8..15, then 0..7.
3. mode=2 -> after 23 is accepted: busy=0, addr_valid=0, flash_address stays 23. A second start restarts at 0 with busy=1 next cycle.
4. dwell=0, addr_ready held low 5 cycles while addr_valid=1 -> flash_address constant and no frame_done. Raising ready advances by exactly 1.
5. dwell=7, en dropped after 3 cycles of hold for 10 cycles -> addr_valid low throughout. After en returns, addr_valid rises 5 cycles later.
6. rst=1 mid-frame, with start also high -> next edge: IDLE, all outputs at reset values. No playback until a start after rst falls.
